inv_key_schedule: RTL and testbench

Streams AES-128 decryption round keys on the fly, from round 10 down to round 0, with one key per accepted handshake. It accepts either the round-10 key directly or the cipher key. Given the cipher key, it first runs the forward schedule internally for 10 cycles to reach round 10, then reverses. It sits between key loading and the inverse-cipher datapath, replacing the 1408-bit full key store with a single 128-bit working register.

---
 rtl/inv_key_schedule.sv | 152 +++++++++++++++
 tb/tb_inv_key_schedule.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// AES-128 decryption key streamer: emits round keys 10 down to 0 from a single working register,
// optionally running the forward schedule first when handed the cipher key.
module inv_key_schedule (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [127:0] i_Key,
  input  logic         i_fKeyIsLast,
  input  logic         i_fStart,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_Round,
  output logic         o_fValid,
  input  logic         i_fReady,
  output logic         o_fBusy,
  output logic         o_fDone
);

  typedef enum logic [1:0] {StIdle, StFwd, StEmit, StDone} state_e;

  // Forward S-box, byte 0x00 in the top 8 bits.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SboxTable << {b, 3'b000};
    return t[2047:2040];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    unique case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;

  logic [31:0]  c0, c1, c2, c3;
  logic [31:0]  q1, q2, q3;
  logic [31:0]  sub_src, rot_w, sub_w, mix_w;
  logic [31:0]  n0, n1, n2, n3, q0;
  logic [3:0]   rcon_idx;
  logic [127:0] fwd_key, inv_key;

  // One SubWord datapath serves both directions; only its source word and Rcon index differ.
  always_comb begin
    c0 = key_q[127:96];
    c1 = key_q[95:64];
    c2 = key_q[63:32];
    c3 = key_q[31:0];
    q3 = c3 ^ c2;
    q2 = c2 ^ c1;
    q1 = c1 ^ c0;
    sub_src  = (state_q == StFwd) ? c3 : q3;
    rcon_idx = (state_q == StFwd) ? round_q + 4'd1 : round_q;
    rot_w = {sub_src[23:0], sub_src[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    mix_w = sub_w ^ {rcon(rcon_idx), 24'h0};
    n0 = c0 ^ mix_w;
    n1 = c1 ^ n0;
    n2 = c2 ^ n1;
    n3 = c3 ^ n2;
    q0 = c0 ^ mix_w;
    fwd_key = {n0, n1, n2, n3};
    inv_key = {q0, q1, q2, q3};
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    unique case (state_q)
      StIdle: begin
        if (i_fStart) begin
          key_d = i_Key;
          if (i_fKeyIsLast) begin
            round_d = 4'd10;
            state_d = StEmit;
          end else begin
            round_d = 4'd0;
            state_d = StFwd;
          end
        end
      end
      StFwd: begin
        key_d   = fwd_key;
        round_d = round_q + 4'd1;
        if (round_q == 4'd9) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (i_fReady) begin
          if (round_q == 4'd0) begin
            state_d = StDone;
          end else begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
    end
  end

  always_comb begin
    o_RoundKey = key_q;
    o_Round    = round_q;
    o_fValid   = (state_q == StEmit);
    o_fBusy    = (state_q != StIdle);
    o_fDone    = (state_q == StDone);
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 example key schedule.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_is_last;
  logic         start;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic         valid;
  logic         ready;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_keys [0:10];

  inv_key_schedule dut (
    .i_Clk       (clk),
    .i_Rst       (rst_n),
    .i_Key       (key),
    .i_fKeyIsLast(key_is_last),
    .i_fStart    (start),
    .o_RoundKey  (round_key),
    .o_Round     (round),
    .o_fValid    (valid),
    .i_fReady    (ready),
    .o_fBusy     (busy),
    .o_fDone     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [127:0] k, input logic last);
    start       = 1'b1;
    key         = k;
    key_is_last = last;
    tick();
    start = 1'b0;
  endtask

  // Drains one full sequence, checking every key against exp_keys; leaves us at the DONE cycle.
  task automatic run_emit(input bit rnd_ready, input bit poke_start);
    int  hs;
    int  cyc;
    bit  took;
    hs  = 0;
    cyc = 0;
    while (hs < 11 && cyc < 300) begin
      check("emit_valid", 128'(valid), 128'(1));
      check("emit_round", 128'(round), 128'(10 - hs));
      check("emit_key", round_key, exp_keys[10 - hs]);
      ready       = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start       = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      key         = {$urandom, $urandom, $urandom, $urandom};
      key_is_last = 1'($urandom_range(0, 1));
      took        = ready;
      tick();
      cyc++;
      if (took) hs++;
    end
    check("handshakes", 128'(hs), 128'(11));
    check("done_pulse", 128'(done), 128'(1));
    check("done_valid", 128'(valid), 128'(0));
    check("done_key", round_key, exp_keys[0]);
    ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int n;
    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n       = 1'b0;
    key         = '1;
    key_is_last = 1'b0;
    start       = 1'b0;
    ready       = 1'b0;
    repeat (3) tick();
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_round", 128'(round), 128'(0));
    check("rst_key", round_key, 128'h0);
    rst_n = 1'b1;
    tick();

    // Cipher key, ready held high, starts poked during FWD.
    ready = 1'b1;
    start_job(exp_keys[0], 1'b0);
    check("fwd_busy", 128'(busy), 128'(1));
    check("fwd_valid", 128'(valid), 128'(0));
    n = 0;
    repeat (4) begin
      start       = 1'b1;
      key         = {$urandom, $urandom, $urandom, $urandom};
      key_is_last = 1'b1;
      tick();
      n++;
    end
    start = 1'b0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    check("fwd_latency", 128'(n), 128'(10));
    run_emit(1'b0, 1'b0);
    tick();
    check("idle_done", 128'(done), 128'(0));
    check("idle_busy", 128'(busy), 128'(0));

    // Round-10 key, random backpressure, stray starts during EMIT.
    start_job(exp_keys[10], 1'b1);
    run_emit(1'b1, 1'b1);
    start       = 1'b1;
    key         = exp_keys[10];
    key_is_last = 1'b1;
    tick();
    check("idle2_done", 128'(done), 128'(0));
    check("idle2_busy", 128'(busy), 128'(0));
    check("idle2_key", round_key, exp_keys[0]);
    tick();
    start = 1'b0;
    check("restart_valid", 128'(valid), 128'(1));
    check("restart_round", 128'(round), 128'(10));
    run_emit(1'b0, 1'b0);
    tick();

    // Reset mid-EMIT at round 5 with a handshake pending.
    ready = 1'b1;
    start_job(exp_keys[10], 1'b1);
    repeat (5) tick();
    check("pre_rst_round", 128'(round), 128'(5));
    check("pre_rst_key", round_key, exp_keys[5]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 128'(valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_round", 128'(round), 128'(0));
    check("mid_rst_key", round_key, 128'h0);
    check("mid_rst_done", 128'(done), 128'(0));
    repeat (3) begin
      tick();
      check("post_rst_valid", 128'(valid), 128'(0));
      check("post_rst_done", 128'(done), 128'(0));
    end

    // All-zero cipher key.
    ready = 1'b0;
    start_job(128'h0, 1'b0);
    n = 1;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    check("zero_latency", 128'(n), 128'(11));
    check("zero_r10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check("zero_round", 128'(round), 128'(10 - i));
      tick();
    end
    check("zero_done", 128'(done), 128'(1));
    check("zero_r0", round_key, 128'h0);
    ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
